// File: rtl/hazard_pkg.sv
// hazard_pkg: shared constants, scoreboard entry type and tnew decrement helper
package hazard_pkg;
    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_E = 2'd1;
    localparam logic [1:0] FWD_M = 2'd2;
    localparam logic [1:0] FWD_W = 2'd3;
    localparam logic [1:0] TUSE_NONE = 2'd3;
    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF = 10;
    typedef struct packed {
        logic [4:0] dst;
        logic [1:0] tnew;
    } sb_entry_t;
    function automatic logic [1:0] sat_dec(input logic [1:0] x);
        return x == 2'd0 ? 2'd0 : x - 2'd1;
    endfunction
endpackage

// File: rtl/hazard_port_check.sv
// hazard_port_check: nearest-writer lookup for one source register, yielding stall or forward select
module hazard_port_check import hazard_pkg::*; (
    input  logic [4:0] rn,
    input  logic [1:0] tuse,
    input  sb_entry_t  e,
    input  sb_entry_t  m,
    input  sb_entry_t  w,
    output logic       stall,
    output logic [1:0] fwd
);
    logic chk, e_hit, m_hit, w_hit;
    logic [1:0] tn;
    always_comb begin
        chk = rn != 5'd0 && tuse != TUSE_NONE;
        e_hit = chk && e.dst == rn;
        m_hit = chk && m.dst == rn;
        w_hit = chk && w.dst == rn;
        tn = e_hit ? e.tnew : m_hit ? m.tnew : w.tnew;
        stall = (e_hit | m_hit | w_hit) && tn > tuse;
        fwd = stall ? FWD_RF : e_hit ? FWD_E : m_hit ? FWD_M : w_hit ? FWD_W : FWD_RF;
    end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: E/M/W writer scoreboard, mult/div busy counter and stall/forward generation
module hazard_ctrl import hazard_pkg::*; #(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic [1:0] id_tuse_rs,
    input  logic [1:0] id_tuse_rt,
    input  logic [4:0] id_dst,
    input  logic [1:0] id_tnew,
    input  logic       id_md_start,
    input  logic       id_md_div,
    input  logic       id_md_use,
    output logic       stall,
    output logic [1:0] fwd_rs,
    output logic [1:0] fwd_rt,
    output logic       md_busy
);
    localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);
    sb_entry_t e_q, m_q, w_q;
    logic [CW-1:0] cnt_q;
    logic rs_stall, rt_stall;
    hazard_port_check u_rs (
        .rn(id_rs), .tuse(id_tuse_rs), .e(e_q), .m(m_q), .w(w_q), .stall(rs_stall), .fwd(fwd_rs)
    );
    hazard_port_check u_rt (
        .rn(id_rt), .tuse(id_tuse_rt), .e(e_q), .m(m_q), .w(w_q), .stall(rt_stall), .fwd(fwd_rt)
    );
    assign md_busy = cnt_q != '0;
    assign stall = rs_stall | rt_stall | (id_md_use & md_busy);
    always_ff @(posedge clk) begin
        if (reset || req) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            w_q <= sb_entry_t'{m_q.dst, sat_dec(m_q.tnew)};
            m_q <= sb_entry_t'{e_q.dst, sat_dec(e_q.tnew)};
            e_q <= stall ? '0 : sb_entry_t'{id_dst, sat_dec(id_tnew)};
        end
    end
    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else if (id_md_start && !stall && !req)
            cnt_q <= id_md_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        else if (md_busy)
            cnt_q <= cnt_q - 1'b1;
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and random stimulus checked against a writer-age model of the pipeline
module tb_hazard_ctrl;
    logic clk = 1'b0, reset = 1'b1, req = 1'b0;
    logic [4:0] id_rs = 5'd0, id_rt = 5'd0, id_dst = 5'd0;
    logic [1:0] id_tuse_rs = 2'd3, id_tuse_rt = 2'd3, id_tnew = 2'd0;
    logic id_md_start = 1'b0, id_md_div = 1'b0, id_md_use = 1'b0;
    logic stall, md_busy;
    logic [1:0] fwd_rs, fwd_rt;

    hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .req(req), .id_rs(id_rs), .id_rt(id_rt),
        .id_tuse_rs(id_tuse_rs), .id_tuse_rt(id_tuse_rt), .id_dst(id_dst), .id_tnew(id_tnew),
        .id_md_start(id_md_start), .id_md_div(id_md_div), .id_md_use(id_md_use),
        .stall(stall), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt), .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    // writer that left ID k edges ago sits at age k (1 = E, 2 = M, 3 = W)
    bit hv[1:3];
    int hd[1:3];
    int ht[1:3];
    int cyc = 0;
    int md_end = 0;
    int checks = 0, errors = 0;
    bit lit_en = 1'b0;
    string lit_name = "";
    int lit_s = 0, lit_fr = 0, lit_ft = 0, lit_b = 0;

    function automatic void port_model(input int r, input int tu, output int s, output int f);
        bit found = 1'b0;
        s = 0;
        f = 0;
        if (r != 0 && tu != 3)
            for (int k = 1; k <= 3; k++)
                if (!found && hv[k] && hd[k] == r) begin
                    found = 1'b1;
                    if ((ht[k] > k ? ht[k] - k : 0) > tu) s = 1;
                    else f = k;
                end
    endfunction

    function automatic int model_stall();
        int s1, s2, f1, f2;
        port_model(int'(id_rs), int'(id_tuse_rs), s1, f1);
        port_model(int'(id_rt), int'(id_tuse_rt), s2, f2);
        return (s1 != 0 || s2 != 0 || (id_md_use && cyc < md_end)) ? 1 : 0;
    endfunction

    always @(posedge clk) begin : model
        int s;
        s = model_stall();
        if (reset) begin
            for (int k = 1; k <= 3; k++) hv[k] = 1'b0;
            md_end = 0;
        end else begin
            if (id_md_start && s == 0 && !req) md_end = cyc + 1 + (id_md_div ? 10 : 5);
            if (req) begin
                for (int k = 1; k <= 3; k++) hv[k] = 1'b0;
            end else begin
                for (int k = 3; k >= 2; k--) begin
                    hv[k] = hv[k-1];
                    hd[k] = hd[k-1];
                    ht[k] = ht[k-1];
                end
                hv[1] = s == 0 && id_dst != 5'd0;
                hd[1] = int'(id_dst);
                ht[1] = int'(id_tnew);
            end
        end
        cyc++;
    end

    task automatic check(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", n, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin : cmp
        int s1, s2, f1, f2, eb;
        port_model(int'(id_rs), int'(id_tuse_rs), s1, f1);
        port_model(int'(id_rt), int'(id_tuse_rt), s2, f2);
        eb = cyc < md_end ? 1 : 0;
        check("stall", int'(stall), model_stall());
        check("fwd_rs", int'(fwd_rs), f1);
        check("fwd_rt", int'(fwd_rt), f2);
        check("md_busy", int'(md_busy), eb);
        if (lit_en) begin
            check({lit_name, ".stall"}, int'(stall), lit_s);
            check({lit_name, ".fwd_rs"}, int'(fwd_rs), lit_fr);
            check({lit_name, ".fwd_rt"}, int'(fwd_rt), lit_ft);
            check({lit_name, ".md_busy"}, int'(md_busy), lit_b);
        end
    end

    task automatic drive(input logic rst, input logic rq, input logic [4:0] rs, input logic [1:0] trs,
                         input logic [4:0] rt, input logic [1:0] trt, input logic [4:0] dst,
                         input logic [1:0] tn, input logic st, input logic dv, input logic us);
        reset = rst; req = rq; id_rs = rs; id_tuse_rs = trs; id_rt = rt; id_tuse_rt = trt;
        id_dst = dst; id_tnew = tn; id_md_start = st; id_md_div = dv; id_md_use = us;
        lit_en = 1'b0;
    endtask

    task automatic expect_lit(input string n, input int s, input int fr, input int ft, input int b);
        lit_en = 1'b1; lit_name = n; lit_s = s; lit_fr = fr; lit_ft = ft; lit_b = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 3, 0, 3, 0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        drive(1, 0, 0, 3, 0, 3, 0, 0, 0, 0, 0);
        tick(); tick();
        idle(0); expect_lit("reset", 0, 0, 0, 0); tick();
        drive(0, 0, 0, 3, 0, 3, 8, 3, 0, 0, 0); tick();
        drive(0, 0, 8, 1, 0, 3, 0, 0, 0, 0, 0); expect_lit("load_use_stall", 1, 0, 0, 0); tick();
        drive(0, 0, 8, 1, 0, 3, 0, 0, 0, 0, 0); expect_lit("load_use_fwd", 0, 2, 0, 0); tick();
        idle(4);
        drive(0, 0, 0, 3, 0, 3, 9, 2, 0, 0, 0); tick();
        drive(0, 0, 9, 0, 0, 3, 0, 0, 0, 0, 0); expect_lit("branch_stall", 1, 0, 0, 0); tick();
        drive(0, 0, 9, 0, 0, 3, 0, 0, 0, 0, 0); expect_lit("branch_fwd", 0, 2, 0, 0); tick();
        idle(4);
        drive(0, 0, 0, 3, 0, 3, 0, 3, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); expect_lit("zero_reg", 0, 0, 0, 0); tick();
        idle(3);
        drive(0, 0, 0, 3, 0, 3, 4, 1, 0, 0, 0); tick();
        drive(0, 0, 0, 3, 0, 3, 4, 1, 0, 0, 0); tick();
        drive(0, 0, 4, 0, 4, 1, 0, 0, 0, 0, 0); expect_lit("e_over_m", 0, 1, 1, 0); tick();
        idle(4);
        drive(0, 0, 0, 3, 0, 3, 0, 0, 1, 0, 1); tick();
        for (int i = 1; i <= 5; i++) begin
            drive(0, 0, 0, 3, 0, 3, 0, 0, 0, 0, 1); expect_lit("mult_busy", 1, 0, 0, 1); tick();
        end
        drive(0, 0, 0, 3, 0, 3, 0, 0, 0, 0, 1); expect_lit("mult_done", 0, 0, 0, 0); tick();
        drive(0, 0, 0, 3, 0, 3, 0, 0, 1, 1, 1); tick();
        for (int i = 1; i <= 10; i++) begin
            drive(0, 0, 0, 3, 0, 3, 0, 0, 0, 0, 1); expect_lit("div_busy", 1, 0, 0, 1); tick();
        end
        drive(0, 0, 0, 3, 0, 3, 0, 0, 0, 0, 1); expect_lit("div_done", 0, 0, 0, 0); tick();
        idle(2);
        drive(0, 0, 0, 3, 0, 3, 8, 3, 1, 0, 0); tick();
        drive(0, 1, 8, 1, 0, 3, 0, 0, 0, 0, 0); expect_lit("flush_cycle", 1, 0, 0, 1); tick();
        drive(0, 0, 8, 1, 0, 3, 0, 0, 0, 0, 0); expect_lit("flush_next", 0, 0, 0, 1); tick();
        idle(2);
        expect_lit("flush_cnt_last", 0, 0, 0, 1); tick();
        expect_lit("flush_cnt_done", 0, 0, 0, 0); tick();
        drive(0, 0, 0, 3, 0, 3, 5, 3, 1, 1, 0); tick();
        idle(3);
        drive(0, 0, 0, 3, 0, 3, 6, 3, 0, 0, 0); tick();
        drive(1, 0, 6, 0, 0, 3, 0, 0, 0, 0, 1); expect_lit("pre_reset", 1, 0, 0, 1); tick();
        drive(0, 0, 6, 0, 5, 0, 0, 0, 0, 0, 1); expect_lit("post_reset", 0, 0, 0, 0); tick();
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(99) == 0, $urandom_range(24) == 0,
                  5'($urandom_range(7)), 2'($urandom_range(3)), 5'($urandom_range(7)), 2'($urandom_range(3)),
                  5'($urandom_range(7)), 2'($urandom_range(3)),
                  $urandom_range(7) == 0, 1'($urandom_range(1)), $urandom_range(3) == 0);
            tick();
        end
        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Hazard and forwarding controller for the five-stage pipeline. It generates the `stall` and forwarding selects that the ID/EX pipeline register and the ID/EX operand muxes consume. It keeps its own shadow scoreboard of in-flight register writers in the E, M and W stages, plus a multiply/divide busy counter. It sits beside the ID stage; the exception flush `req` is the same signal that flushes the pipeline registers.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu
- DIV_CYCLES, 10, busy cycles for div/divu

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req  in  1  exception/eret flush; same cycle as pipeline-register flush
- id_rs  in  5  ID source register 1
- id_rt  in  5  ID source register 2
- id_tuse_rs  in  2  cycles until rs is needed (0 = ID, 1 = EX, 2 = MEM); 3 = unused
- id_tuse_rt  in  2  same for rt
- id_dst  in  5  ID destination register; 0 = no write
- id_tnew  in  2  ID-stage Tnew (cycles from ID until the result exists); load 3, ALU 2, link/lui 1
- id_md_start  in  1  ID instruction starts the mult/div unit
- id_md_div  in  1  qualifies id_md_start: 1 = divide, 0 = multiply
- id_md_use  in  1  ID instruction accesses the mult/div unit (mf/mt hi/lo, mult, div)
- stall  out  1  freeze PC and IF/ID; insert a bubble into ID/EX
- fwd_rs  out  2  rs operand source: 0 regfile, 1 E, 2 M, 3 W
- fwd_rt  out  2  rt operand source, same encoding
- md_busy  out  1  mult/div counter nonzero

## Operation
- Scoreboard holds three entries, E, M and W. Each entry is {dst[4:0], tnew[1:0]}. An entry with dst = 0 is empty.
- Per-cycle update on the clock edge, in priority order:
  - reset: all entries {0,0}; counter 0.
  - req: all entries {0,0}. The counter continues to decrement and is not reloaded.
  - normal: W ← M with tnew sat-decremented; M ← E with tnew sat-decremented; E ← {0,0} if stall, else {id_dst, sat_dec(id_tnew)}.
  - sat_dec(x) = x − 1 if x ≠ 0, else 0.
- Port check, identical for rs and rt and evaluated combinationally:
  - Skip the check when the register is 0 or tuse = 3; result is no stall, fwd 0.
  - Otherwise find the nearest matching entry, in priority E > M > W.
  - No match: fwd 0, no stall.
  - Match with entry.tnew > tuse: stall, and fwd is don't-care (driven 0).
  - Match with entry.tnew ≤ tuse: fwd = the stage of that entry.
- Mult/div counter:
  - Load condition: id_md_start && !stall && !req && !reset. On that edge the counter loads DIV_CYCLES if id_md_div, else MULT_CYCLES.
  - Otherwise the counter decrements when nonzero.
  - md_busy = (count ≠ 0).
- stall = rs_stall | rt_stall | (id_md_use & md_busy).
- stall and req may both be high; req has priority and the E entry is cleared.

## Timing
- All outputs are combinational from current state plus ID inputs. There is no added latency.
- After reset, with idle ID inputs: stall 0, fwd_rs 0, fwd_rt 0, md_busy 0.
- A writer reaches E one edge after it leaves ID unstalled, M one edge later, W one edge after that, and is dropped on the following edge.
- A W entry always has tnew 0. The register file does not bypass internally, so W forwarding is mandatory.
- The counter reaches 0 exactly N cycles after the load edge, N = MULT_CYCLES or DIV_CYCLES.
- Reset mid-operation clears everything on that edge.

## Structure
- hazard_pkg contains:
  - constants FWD_RF = 0, FWD_E = 1, FWD_M = 2, FWD_W = 3, TUSE_NONE = 3;
  - default MULT_CYCLES and DIV_CYCLES;
  - the scoreboard entry typedef {dst, tnew}.
- Sub-module hazard_port_check (combinational) takes {reg, tuse, E, M, W entries} and returns {stall, fwd}. It is instantiated twice, once for rs and once for rt.
- The top level holds the scoreboard registers, the counter and the stall OR.

## Test plan
- Load-use: cycle 0 ID has dst = 8, tnew = 3; cycle 1 ID has rs = 8, tuse = 1.
  - Cycle 1: E = {8, 2} → stall = 1.
  - Cycle 2: M = {8, 1}, E empty → stall = 0, fwd_rs = 2.
- ALU→branch: cycle 0 ID has dst = 9, tnew = 2; cycle 1 ID has rs = 9, tuse = 0.
  - Cycle 1: stall = 1.
  - Cycle 2: M = {9, 0} → fwd_rs = 2, stall = 0.
- $0 and priority:
  - A writer with id_dst = 0 never stalls or forwards.
  - With E = {4, 0} and M = {4, 0}, an ID reader with rt = 4, tuse = 1 → fwd_rt = 1.
- Mult/div: mult issued unstalled in cycle 0, then mflo (id_md_use = 1) held in ID from cycle 1.
  - stall = 1 in cycles 1–5; stall = 0 in cycle 6.
  - With id_md_div = 1 the stall lasts cycles 1–10.
- Flush beats stall: cycle 1 of the load-use case with req = 1.
  - Next cycle: all entries empty, stall = 0, fwd = 0.
  - A running counter still reaches 0 on schedule.
- Reset mid-divide at count = 6: next cycle md_busy = 0, stall = 0, and all fwd outputs = 0.
